// File: rtl/axi128_apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : axi128_apb_bridge
//  Brief    : Single-outstanding AXI3 (128-bit) slave to APB (32-bit) bridge.
//             Each AXI data beat becomes one APB transfer; reads and writes
//             are serialized with round-robin arbitration.
//  Options  : define AXI2APB_TIMEOUT_EN to bound the APB access phase to
//             TIMEOUT_CYCLES cycles (expired beats complete with SLVERR).
//  Revision : 1.0 - initial release
// ============================================================================
module axi128_apb_bridge #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic         i_aclk,
  input  logic         i_aresetn,
  // Write address
  input  logic [3:0]   i_awid,
  input  logic [31:0]  i_awaddr,
  input  logic [3:0]   i_awlen,
  input  logic [2:0]   i_awsize,
  input  logic [1:0]   i_awburst,
  input  logic [2:0]   i_awprot,
  input  logic [1:0]   i_awlock,
  input  logic [3:0]   i_awcache,
  input  logic         i_awvalid,
  output logic         o_awready,
  // Write data
  input  logic [3:0]   i_wid,
  input  logic [127:0] i_wdata,
  input  logic [15:0]  i_wstrb,
  input  logic         i_wlast,
  input  logic         i_wvalid,
  output logic         o_wready,
  // Write response
  output logic [3:0]   o_bid,
  output logic [1:0]   o_bresp,
  output logic         o_bvalid,
  input  logic         i_bready,
  // Read address
  input  logic [3:0]   i_arid,
  input  logic [31:0]  i_araddr,
  input  logic [3:0]   i_arlen,
  input  logic [2:0]   i_arsize,
  input  logic [1:0]   i_arburst,
  input  logic [2:0]   i_arprot,
  input  logic [1:0]   i_arlock,
  input  logic [3:0]   i_arcache,
  input  logic         i_arvalid,
  output logic         o_arready,
  // Read data
  output logic [3:0]   o_rid,
  output logic [127:0] o_rdata,
  output logic [1:0]   o_rresp,
  output logic         o_rlast,
  output logic         o_rvalid,
  input  logic         i_rready,
  // APB
  output logic         o_psel,
  output logic         o_penable,
  output logic         o_pwrite,
  output logic [31:0]  o_paddr,
  output logic [31:0]  o_pwdata,
  output logic [2:0]   o_pprot,
  output logic [3:0]   o_pstrb,
  input  logic [31:0]  i_prdata,
  input  logic         i_pready,
  input  logic         i_pslverr
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_W_DATA   = 3'd1;
  localparam logic [2:0] c_W_SETUP  = 3'd2;
  localparam logic [2:0] c_W_ACCESS = 3'd3;
  localparam logic [2:0] c_W_RESP   = 3'd4;
  localparam logic [2:0] c_R_SETUP  = 3'd5;
  localparam logic [2:0] c_R_ACCESS = 3'd6;
  localparam logic [2:0] c_R_DATA   = 3'd7;

  localparam logic [1:0] c_RESP_OK     = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;

  logic [2:0]   r_state;
  logic [3:0]   r_id;
  logic [31:0]  r_addr;
  logic [3:0]   r_len;
  logic [2:0]   r_size;
  logic [1:0]   r_burst;
  logic [2:0]   r_prot;
  logic [3:0]   r_beat;
  logic         r_err;
  logic         r_last_wr;
  logic [31:0]  r_pwdata;
  logic [3:0]   r_pstrb;
  logic [127:0] r_rdata;
  logic [1:0]   r_rresp;

  logic         w_grant_wr;
  logic         w_grant_rd;
  logic         w_size_ok;
  logic         w_last;
  logic [1:0]   w_lane;
  logic         w_in_access;
  logic         w_tmo;
  logic         w_done;
  logic         w_beat_err;
  logic [31:0]  w_prdata_eff;
  logic [127:0] w_rdata_beat;
  logic [31:0]  w_step;
  logic [31:0]  w_wrap_mask;
  logic [31:0]  w_next_addr;
  logic         w_unused;

  // Write wins a tie unless it was the last channel granted.
  assign w_grant_wr = i_awvalid && (!i_arvalid || !r_last_wr);
  assign w_grant_rd = i_arvalid && !w_grant_wr;

  assign w_size_ok   = (r_size <= 3'd2);
  assign w_last      = (r_beat == r_len);
  assign w_lane      = r_addr[3:2];
  assign w_in_access = (r_state == c_W_ACCESS) || (r_state == c_R_ACCESS);
  assign w_done      = i_pready || w_tmo;
  // A beat that completes without pready can only be a timeout.
  assign w_beat_err   = i_pready ? i_pslverr : 1'b1;
  assign w_prdata_eff = i_pready ? i_prdata : 32'd0;
  assign w_rdata_beat = {96'd0, w_prdata_eff} << {w_lane, 5'b00000};

`ifdef AXI2APB_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;

  // Count access cycles of the current beat; restart outside a waiting ACCESS.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_tmo_cnt <= '0;
    end else if (w_in_access && !w_done) begin
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_tmo = w_in_access && !i_pready && (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  // Next beat address: FIXED holds, WRAP stays in its aligned block, else INCR.
  always_comb begin
    w_step      = 32'd1 << r_size;
    w_wrap_mask = ({28'd0, r_len} << r_size) + (w_step - 32'd1);
    case (r_burst)
      2'b00:   w_next_addr = r_addr;
      2'b10:   w_next_addr = (r_addr & ~w_wrap_mask) | ((r_addr + w_step) & w_wrap_mask);
      default: w_next_addr = r_addr + w_step;
    endcase
  end

  // Main control: arbitration, burst unrolling and APB sequencing.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state   <= c_IDLE;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_prot    <= '0;
      r_beat    <= '0;
      r_err     <= 1'b0;
      r_last_wr <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_rdata   <= '0;
      r_rresp   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_grant_wr) begin
            r_id      <= i_awid;
            r_addr    <= i_awaddr;
            r_len     <= i_awlen;
            r_size    <= i_awsize;
            r_burst   <= i_awburst;
            r_prot    <= i_awprot;
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_last_wr <= 1'b1;
            r_state   <= c_W_DATA;
          end else if (w_grant_rd) begin
            r_id      <= i_arid;
            r_addr    <= i_araddr;
            r_len     <= i_arlen;
            r_size    <= i_arsize;
            r_burst   <= i_arburst;
            r_prot    <= i_arprot;
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_last_wr <= 1'b0;
            if (i_arsize > 3'd2) begin
              r_rdata <= '0;
              r_rresp <= c_RESP_SLVERR;
              r_state <= c_R_DATA;
            end else begin
              r_state <= c_R_SETUP;
            end
          end
        end
        c_W_DATA: begin
          if (i_wvalid) begin
            if (w_size_ok) begin
              r_pwdata <= i_wdata[{w_lane, 5'b00000} +: 32];
              r_pstrb  <= i_wstrb[{w_lane, 2'b00} +: 4];
              r_state  <= c_W_SETUP;
            end else begin
              // Wide beats cannot map onto APB: swallow and flag them.
              r_err   <= 1'b1;
              r_addr  <= w_next_addr;
              r_beat  <= r_beat + 4'd1;
              r_state <= w_last ? c_W_RESP : c_W_DATA;
            end
          end
        end
        c_W_SETUP: begin
          r_state <= c_W_ACCESS;
        end
        c_W_ACCESS: begin
          if (w_done) begin
            r_err   <= r_err | w_beat_err;
            r_addr  <= w_next_addr;
            r_beat  <= r_beat + 4'd1;
            r_state <= w_last ? c_W_RESP : c_W_DATA;
          end
        end
        c_W_RESP: begin
          if (i_bready) begin
            r_state <= c_IDLE;
          end
        end
        c_R_SETUP: begin
          r_state <= c_R_ACCESS;
        end
        c_R_ACCESS: begin
          if (w_done) begin
            r_rdata <= w_rdata_beat;
            r_rresp <= w_beat_err ? c_RESP_SLVERR : c_RESP_OK;
            r_addr  <= w_next_addr;
            r_state <= c_R_DATA;
          end
        end
        c_R_DATA: begin
          if (i_rready) begin
            if (w_last) begin
              r_state <= c_IDLE;
            end else begin
              r_beat <= r_beat + 4'd1;
              if (w_size_ok) begin
                r_state <= c_R_SETUP;
              end else begin
                r_rdata <= '0;
                r_rresp <= c_RESP_SLVERR;
                r_state <= c_R_DATA;
              end
            end
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Handshake and APB control are decoded from the state.
  assign o_awready = (r_state == c_IDLE) && w_grant_wr;
  assign o_arready = (r_state == c_IDLE) && w_grant_rd;
  assign o_wready  = (r_state == c_W_DATA);
  assign o_bvalid  = (r_state == c_W_RESP);
  assign o_bid     = r_id;
  assign o_bresp   = ((r_state == c_W_RESP) && r_err) ? c_RESP_SLVERR : c_RESP_OK;
  assign o_rvalid  = (r_state == c_R_DATA);
  assign o_rlast   = (r_state == c_R_DATA) && w_last;
  assign o_rid     = r_id;
  assign o_rdata   = r_rdata;
  assign o_rresp   = r_rresp;

  assign o_psel    = (r_state == c_W_SETUP) || (r_state == c_W_ACCESS) ||
                     (r_state == c_R_SETUP) || (r_state == c_R_ACCESS);
  assign o_penable = w_in_access;
  assign o_pwrite  = (r_state == c_W_SETUP) || (r_state == c_W_ACCESS);
  assign o_paddr   = {r_addr[31:2], 2'b00};
  assign o_pwdata  = r_pwdata;
  assign o_pstrb   = r_pstrb;
  assign o_pprot   = r_prot;

  // Sideband fields the bridge deliberately ignores.
  assign w_unused = (^{i_awlock, i_awcache, i_wid, i_wlast, i_arlock, i_arcache}) ^
                    (TIMEOUT_CYCLES == 0);

endmodule
`default_nettype wire
